operand_issue: RTL and testbench

- Parametrised, registered successor to the combinational operand picker in the vector-processor execute path.
- Sits between register-file read and the execute units.
- Selects op1/op2 per functype, generalised to LANES x LANE_W vectors, and adds an SMUL scalar-broadcast mode.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides. Optional writeback bypass.

---
 rtl/operand_pkg.sv | 55 +++++
 rtl/operand_select.sv | 57 +++++
 rtl/operand_issue.sv | 165 ++++++++++++++++
 tb/tb_operand_issue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | operand_pkg : functype codes, skid-buffer states, sign-extend/broadcast helpers
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
package operand_pkg;

   localparam logic [3:0] VADD = 4'd0;
   localparam logic [3:0] VDOT = 4'd1;
   localparam logic [3:0] SMUL = 4'd2;
   localparam logic [3:0] SST  = 4'd3;
   localparam logic [3:0] VLD  = 4'd4;
   localparam logic [3:0] VST  = 4'd5;
   localparam logic [3:0] SLL  = 4'd6;
   localparam logic [3:0] SLH  = 4'd7;
   localparam logic [3:0] J    = 4'd8;
   localparam logic [3:0] NOP  = 4'hF;

   // Helpers work on fixed maximum widths; callers size-cast the result down.
   localparam int MAX_SW    = 64;
   localparam int MAX_LANES = 256;
   localparam int MAX_VW    = 4096;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   function automatic logic [MAX_SW-1:0] sext(input logic [MAX_SW-1:0] v,
                                              input int unsigned        from_w);
      logic [MAX_SW-1:0] m;
      m = {MAX_SW{1'b1}} << from_w;
      if (((v >> (from_w - 1)) & MAX_SW'(1)) != '0)
         return v | m;
      else
         return v & ~m;
   endfunction

   function automatic logic [MAX_VW-1:0] broadcast(input logic [MAX_SW-1:0] s,
                                                   input int unsigned        lanes,
                                                   input int unsigned        lane_w);
      logic [MAX_VW-1:0] r;
      logic [MAX_VW-1:0] e;
      r = '0;
      e = MAX_VW'(s & ((MAX_SW'(1) << lane_w) - MAX_SW'(1)));
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         if (i < lanes)
            r = r | (e << (i * lane_w));
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | operand_select : combinational op1/op2 picker per functype
// | Revision       : 1.0
// +-----------------------------------------------------------------------------
module operand_select
   import operand_pkg::*;
#(
   parameter int LANES  = 16,
   parameter int LANE_W = 16,
   parameter int OFF_W  = 6,
   parameter int IMM_W  = 8
) (
   input  logic [3:0]              functype,
   input  logic [LANES*LANE_W-1:0] vdata1,
   input  logic [LANES*LANE_W-1:0] vdata2,
   input  logic [LANE_W-1:0]       sdata1,
   input  logic [LANE_W-1:0]       sdata2,
   input  logic [IMM_W-1:0]        imm,
   input  logic [OFF_W-1:0]        offset,
   input  logic [LANE_W-1:0]       pc,
   output logic [LANES*LANE_W-1:0] op1,
   output logic [LANES*LANE_W-1:0] op2
);

   localparam int VW = LANES * LANE_W;

   always_comb begin
      op1 = '0;
      op2 = '0;
      case (functype)
         VADD, VDOT: begin
            op1 = vdata1;
            op2 = vdata2;
         end
         SMUL: begin
            op1 = vdata1;
            op2 = VW'(broadcast(MAX_SW'(sdata2), LANES, LANE_W));
         end
         VLD, VST, SST: begin
            op1 = VW'(sdata1);
            op2 = VW'(LANE_W'(sext(MAX_SW'(offset), OFF_W)));
         end
         SLL, SLH: begin
            op1 = VW'(sdata1);
            op2 = VW'(imm);
         end
         J: begin
            op1 = VW'(pc);
            op2 = VW'(LANE_W'(sext(MAX_SW'(imm), IMM_W)));
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/operand_issue.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | operand_issue : registered operand picker with 2-entry skid buffer.
// | Optional writeback bypass: OPERAND_ISSUE_BYPASS_EN.      Revision : 1.0
// +-----------------------------------------------------------------------------
module operand_issue
   import operand_pkg::*;
#(
   parameter int LANES  = 16,
   parameter int LANE_W = 16,
   parameter int OFF_W  = 6,
   parameter int IMM_W  = 8,
   parameter int RA_W   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              functype,
   input  logic [LANES*LANE_W-1:0] vdata1,
   input  logic [LANES*LANE_W-1:0] vdata2,
   input  logic [LANE_W-1:0]       sdata1,
   input  logic [LANE_W-1:0]       sdata2,
   input  logic [RA_W-1:0]         vsrc1,
   input  logic [RA_W-1:0]         vsrc2,
   input  logic [RA_W-1:0]         ssrc1,
   input  logic [RA_W-1:0]         ssrc2,
   input  logic [IMM_W-1:0]        imm,
   input  logic [OFF_W-1:0]        offset,
   input  logic [LANE_W-1:0]       pc,
   input  logic                    wb_en,
   input  logic                    wb_is_vec,
   input  logic [RA_W-1:0]         wb_addr,
   input  logic [LANES*LANE_W-1:0] wb_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              out_func,
   output logic [LANES*LANE_W-1:0] op1,
   output logic [LANES*LANE_W-1:0] op2
);

   localparam int VW = LANES * LANE_W;

   logic [VW-1:0]     src_vdata1, src_vdata2;
   logic [LANE_W-1:0] src_sdata1, src_sdata2;
   logic [VW-1:0]     sel_op1, sel_op2;

`ifdef OPERAND_ISSUE_BYPASS_EN
   // Forward the in-flight writeback into the sources so selection sees it.
   always_comb begin
      src_vdata1 = vdata1;
      src_vdata2 = vdata2;
      src_sdata1 = sdata1;
      src_sdata2 = sdata2;
      if (wb_en && wb_is_vec && (wb_addr == vsrc1))   src_vdata1 = wb_data;
      if (wb_en && wb_is_vec && (wb_addr == vsrc2))   src_vdata2 = wb_data;
      if (wb_en && !wb_is_vec && (wb_addr == ssrc1))  src_sdata1 = wb_data[LANE_W-1:0];
      if (wb_en && !wb_is_vec && (wb_addr == ssrc2))  src_sdata2 = wb_data[LANE_W-1:0];
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{wb_en, wb_is_vec, wb_addr, wb_data, vsrc1, vsrc2, ssrc1, ssrc2};
   assign src_vdata1 = vdata1;
   assign src_vdata2 = vdata2;
   assign src_sdata1 = sdata1;
   assign src_sdata2 = sdata2;
`endif

   operand_select #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .OFF_W  (OFF_W),
      .IMM_W  (IMM_W)
   ) u_select (
      .functype (functype),
      .vdata1   (src_vdata1),
      .vdata2   (src_vdata2),
      .sdata1   (src_sdata1),
      .sdata2   (src_sdata2),
      .imm      (imm),
      .offset   (offset),
      .pc       (pc),
      .op1      (sel_op1),
      .op2      (sel_op2)
   );

   skid_state_e   state_q, state_d;
   logic [VW-1:0] main_op1_q, main_op1_d, main_op2_q, main_op2_d;
   logic [VW-1:0] skid_op1_q, skid_op1_d, skid_op2_q, skid_op2_d;
   logic [3:0]    main_func_q, main_func_d, skid_func_q, skid_func_d;
   logic          accept, drain;

   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_func  = main_func_q;
   assign op1       = main_op1_q;
   assign op2       = main_op2_q;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_op1_d  = main_op1_q;
      main_op2_d  = main_op2_q;
      main_func_d = main_func_q;
      skid_op1_d  = skid_op1_q;
      skid_op2_d  = skid_op2_q;
      skid_func_d = skid_func_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_op1_d  = sel_op1;
               main_op2_d  = sel_op2;
               main_func_d = functype;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               main_op1_d  = sel_op1;
               main_op2_d  = sel_op2;
               main_func_d = functype;
            end else if (accept) begin
               skid_op1_d  = sel_op1;
               skid_op2_d  = sel_op2;
               skid_func_d = functype;
               state_d     = ST_TWO;
            end else if (drain) begin
               state_d     = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               main_op1_d  = skid_op1_q;
               main_op2_d  = skid_op2_q;
               main_func_d = skid_func_q;
               state_d     = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_op1_q  <= '0;
         main_op2_q  <= '0;
         main_func_q <= NOP;
         skid_op1_q  <= '0;
         skid_op2_q  <= '0;
         skid_func_q <= NOP;
      end else begin
         state_q     <= state_d;
         main_op1_q  <= main_op1_d;
         main_op2_q  <= main_op2_d;
         main_func_q <= main_func_d;
         skid_op1_q  <= skid_op1_d;
         skid_op2_q  <= skid_op2_d;
         skid_func_q <= skid_func_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_issue.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_operand_issue : scoreboard bench for operand_issue (honours OPERAND_ISSUE_BYPASS_EN)
// | Revision         : 1.0
// +-----------------------------------------------------------------------------
module tb_operand_issue;
   import operand_pkg::*;

   localparam int LANES  = 16;
   localparam int LANE_W = 16;
   localparam int OFF_W  = 6;
   localparam int IMM_W  = 8;
   localparam int RA_W   = 3;
   localparam int VW     = LANES * LANE_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        functype = NOP;
   logic [VW-1:0]     vdata1 = '0, vdata2 = '0;
   logic [LANE_W-1:0] sdata1 = '0, sdata2 = '0;
   logic [RA_W-1:0]   vsrc1 = '0, vsrc2 = '0, ssrc1 = '0, ssrc2 = '0;
   logic [IMM_W-1:0]  imm = '0;
   logic [OFF_W-1:0]  offset = '0;
   logic [LANE_W-1:0] pc = '0;
   logic              wb_en = 1'b0, wb_is_vec = 1'b0;
   logic [RA_W-1:0]   wb_addr = '0;
   logic [VW-1:0]     wb_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [3:0]        out_func;
   logic [VW-1:0]     op1, op2;

   always #5 clk = ~clk;

   operand_issue #(
      .LANES(LANES), .LANE_W(LANE_W), .OFF_W(OFF_W), .IMM_W(IMM_W), .RA_W(RA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .functype(functype), .vdata1(vdata1), .vdata2(vdata2),
      .sdata1(sdata1), .sdata2(sdata2),
      .vsrc1(vsrc1), .vsrc2(vsrc2), .ssrc1(ssrc1), .ssrc2(ssrc2),
      .imm(imm), .offset(offset), .pc(pc),
      .wb_en(wb_en), .wb_is_vec(wb_is_vec), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
      .op1(op1), .op2(op2)
   );

   typedef struct packed {
      logic [3:0]    f;
      logic [VW-1:0] o1;
      logic [VW-1:0] o2;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model of selection (plus bypass when the macro is defined).
   function automatic exp_t calc();
      exp_t              e;
      logic [VW-1:0]     v1, v2;
      logic [LANE_W-1:0] s1, s2;
      v1 = vdata1; v2 = vdata2; s1 = sdata1; s2 = sdata2;
`ifdef OPERAND_ISSUE_BYPASS_EN
      if (wb_en && wb_is_vec && wb_addr == vsrc1)  v1 = wb_data;
      if (wb_en && wb_is_vec && wb_addr == vsrc2)  v2 = wb_data;
      if (wb_en && !wb_is_vec && wb_addr == ssrc1) s1 = wb_data[LANE_W-1:0];
      if (wb_en && !wb_is_vec && wb_addr == ssrc2) s2 = wb_data[LANE_W-1:0];
`endif
      e.f = functype; e.o1 = '0; e.o2 = '0;
      case (functype)
         VADD, VDOT:    begin e.o1 = v1; e.o2 = v2; end
         SMUL:          begin e.o1 = v1; e.o2 = {LANES{s2}}; end
         VLD, VST, SST: begin e.o1 = VW'(s1); e.o2 = VW'({{(LANE_W-OFF_W){offset[OFF_W-1]}}, offset}); end
         SLL, SLH:      begin e.o1 = VW'(s1); e.o2 = VW'(imm); end
         J:             begin e.o1 = VW'(pc); e.o2 = VW'({{(LANE_W-IMM_W){imm[IMM_W-1]}}, imm}); end
         default: ;
      endcase
      return e;
   endfunction

   task automatic set_op(input logic [3:0] f, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [LANE_W-1:0] s1, input logic [LANE_W-1:0] s2,
                         input logic [IMM_W-1:0] im, input logic [OFF_W-1:0] off,
                         input logic [LANE_W-1:0] p);
      functype = f; vdata1 = a; vdata2 = b; sdata1 = s1; sdata2 = s2;
      imm = im; offset = off; pc = p;
   endtask

   task automatic set_rand(input logic [3:0] f);
      functype = f;
      for (int k = 0; k < VW / 32; k++) begin
         vdata1[k*32 +: 32] = $urandom;
         vdata2[k*32 +: 32] = $urandom;
         wb_data[k*32 +: 32] = $urandom;
      end
      sdata1 = LANE_W'($urandom); sdata2 = LANE_W'($urandom);
      imm = IMM_W'($urandom); offset = OFF_W'($urandom); pc = LANE_W'($urandom);
      vsrc1 = RA_W'($urandom); vsrc2 = RA_W'($urandom);
      ssrc1 = RA_W'($urandom); ssrc2 = RA_W'($urandom);
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [VW-1:0] ramp;
      exp_t e;
      for (int i = 0; i < LANES; i++) ramp[i*LANE_W +: LANE_W] = LANE_W'(i + 1);
      rst_n = 1'b0; out_ready = 1'b0;
      set_op(VADD, ramp, ~ramp, 16'h1111, 16'h2222, 8'h12, 6'h05, 16'h0100);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (op1 !== '0) begin errors++; $display("FAIL reset_op1 got %h want 0", op1); end
      checks++; if (op2 !== '0) begin errors++; $display("FAIL reset_op2 got %h want 0", op2); end
      checks++; if (out_func !== 4'hF) begin errors++; $display("FAIL reset_out_func got %h want f", out_func); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      e = calc();
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_release_valid got %0b want 1", out_valid); end
      checks++;
      if ({out_func, op1, op2} !== {e.f, e.o1, e.o2}) begin
         errors++; $display("FAIL reset_first_entry got func %h op1 %h want func %h op1 %h", out_func, op1, e.f, e.o1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got %0b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_smul();
      logic [VW-1:0] ramp;
      exp_t e;
      for (int i = 0; i < LANES; i++) ramp[i*LANE_W +: LANE_W] = LANE_W'(i);
      set_op(SMUL, ramp, '1, 16'h7777, 16'h0003, 8'h00, 6'h00, 16'h0000);
      in_valid = 1'b1; out_ready = 1'b1;
      exp_q.push_back(calc());
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL smul_latency got %0b want 1", out_valid); end
      checks++; if (op2 !== {LANES{16'h0003}}) begin errors++; $display("FAIL smul_broadcast got %h want all 0003", op2); end
      e = exp_q.pop_front();
      checks++;
      if ({out_func, op1, op2} !== {e.f, e.o1, e.o2}) begin
         errors++; $display("FAIL smul_entry got func %h op1 %h want func %h op1 %h", out_func, op1, e.f, e.o1);
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL smul_drain got %0b want 0", out_valid); end
   endtask

   task automatic test_vld_j();
      set_op(VLD, '1, '1, 16'h0100, 16'h5555, 8'h00, 6'b111110, 16'h0000);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      set_op(J, '1, '1, 16'h3333, 16'h4444, 8'h80, 6'h00, 16'h0040);
      checks++;
      if ({out_func, op1, op2} !== {VLD, VW'(16'h0100), VW'(16'hFFFE)}) begin
         errors++; $display("FAIL vld_ops got func %h op1 %h op2 %h want func 4 op1 0100 op2 fffe", out_func, op1, op2);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_func, op1, op2} !== {J, VW'(16'h0040), VW'(16'hFF80)}) begin
         errors++; $display("FAIL j_ops got func %h op1 %h op2 %h want func 8 op1 0040 op2 ff80", out_func, op1, op2);
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_throughput();
      exp_t e;
      out_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (n > 0) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tput_valid cyc %0d got %0b want 1", n, out_valid); end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if ({out_func, op1, op2} !== {e.f, e.o1, e.o2}) begin
                  errors++; $display("FAIL tput_entry cyc %0d got func %h op2 %h want func %h op2 %h", n, out_func, op2, e.f, e.o2);
               end
            end
         end
         set_rand(4'(n % 16));
         in_valid = 1'b1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_in_ready cyc %0d got %0b want 1", n, in_ready); end
         exp_q.push_back(calc());
         @(negedge clk);
      end
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, out_func, op1, op2} !== {1'b1, e.f, e.o1, e.o2}) begin
         errors++; $display("FAIL tput_last got valid %0b func %h want valid 1 func %h", out_valid, out_func, e.f);
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tput_empty got %0b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] funcs [3] = '{VADD, SMUL, J};
      logic [VW*2+3:0] held;
      exp_t e;
      int sent = 0, got = 0;
      logic acc = 1'b0;
      out_ready = 1'b0; in_valid = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         if (acc) in_valid = 1'b0;
         if (cyc == 6) out_ready = 1'b1;
         if (cyc == 2) begin
            held = {out_func, op1, op2};
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full got %0b want 0", in_ready); end
         end
         if (cyc == 5) begin
            checks++;
            if ({out_func, op1, op2} !== held) begin
               errors++; $display("FAIL b2b_hold got func %h want func %h", out_func, held[VW*2 +: 4]);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++; $display("FAIL b2b_extra got func %h want nothing", out_func);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({out_func, op1, op2} !== {e.f, e.o1, e.o2}) begin
                  errors++; $display("FAIL b2b_order idx %0d got func %h want func %h", got, out_func, e.f);
               end
            end
            got++;
         end
         if (sent < 3 && !in_valid) begin
            set_rand(funcs[sent]);
            in_valid = 1'b1;
         end
         acc = in_valid && in_ready;
         if (acc) begin
            exp_q.push_back(calc());
            sent++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      set_rand(VDOT); in_valid = 1'b1;
      @(negedge clk);
      set_rand(SLH);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL midrst_full got %b want 10", {out_valid, in_ready}); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_func, op1, op2} !== {1'b0, 1'b1, 4'hF, {VW{1'b0}}, {VW{1'b0}}}) begin
         errors++; $display("FAIL midrst_clear got valid %0b ready %0b func %h want valid 0 ready 1 func f", out_valid, in_ready, out_func);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got %0b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_bypass();
      exp_t e;
      logic [LANE_W-1:0] want1;
      out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         set_rand(SLL);
         sdata1 = 16'h1234;
         wb_data[LANE_W-1:0] = 16'hBEEF;
         wb_en = 1'b1; wb_is_vec = 1'b0; wb_addr = 3'd3; ssrc1 = 3'd3; ssrc2 = 3'd5;
         case (t)
            1: begin functype = SMUL; wb_addr = 3'd5; end
            2: begin functype = VADD; wb_is_vec = 1'b1; vsrc1 = 3'd3; vsrc2 = 3'd4; end
            3: begin wb_is_vec = 1'b1; vsrc1 = 3'd0; vsrc2 = 3'd1; end
            default: ;
         endcase
         in_valid = 1'b1;
         e = calc();
         @(negedge clk);
         in_valid = 1'b0; wb_en = 1'b0;
         if (t == 0) begin
`ifdef OPERAND_ISSUE_BYPASS_EN
            want1 = 16'hBEEF;
`else
            want1 = 16'h1234;
`endif
            checks++; if (op1 !== VW'(want1)) begin errors++; $display("FAIL bypass_sll got %h want %h", op1[LANE_W-1:0], want1); end
         end
         checks++;
         if ({out_valid, out_func, op1, op2} !== {1'b1, e.f, e.o1, e.o2}) begin
            errors++; $display("FAIL bypass_case %0d got func %h op1 %h want func %h op1 %h", t, out_func, op1, e.f, e.o1);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_smul();
      test_vld_j();
      test_throughput();
      test_back_to_back();
      test_reset_mid();
      test_bypass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
